// File: rtl/float_acc_if.sv
// Operand stream and running-sum bundle for float_acc.
// The master drives operands; the slave (accumulator) drives the sum and status.
interface float_acc_if #(
  parameter int EXP_W  = 3,
  parameter int MANT_W = 5
);
  logic                    in_valid;
  logic                    in_ready;
  logic [EXP_W+MANT_W-1:0] in_data;
  logic                    in_clear;
  logic [EXP_W+MANT_W-1:0] acc;
  logic                    out_valid;
  logic                    ovf;

  modport master (
    output in_valid, in_data, in_clear,
    input  in_ready, acc, out_valid, ovf
  );

  modport slave (
    input  in_valid, in_data, in_clear,
    output in_ready, acc, out_valid, ovf
  );
endinterface

// File: rtl/float_acc.sv
// Multi-cycle accumulator for the unsigned mini-float (value = mantissa << exponent).
// Each accepted operand passes through ALIGN, ADD and NORM before landing in acc.
module float_acc #(
  parameter int EXP_W  = 3,
  parameter int MANT_W = 5
) (
  input logic        clk,
  input logic        reset,
  float_acc_if.slave bus
);
  localparam int W = EXP_W + MANT_W;

  typedef enum logic [1:0] {IDLE, ALIGN, ADD, NORM} state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [W-1:0]        r_opa;
  logic [W-1:0]        r_opb;
  logic [W-1:0]        r_acc;
  logic [EXP_W-1:0]    r_exp;
  logic [MANT_W-1:0]   r_ma;
  logic [MANT_W-1:0]   r_mb;
  logic [MANT_W:0]     r_sum;
  logic                r_out_valid;
  logic                r_ovf;

  logic                w_xfer;
  logic [EXP_W-1:0]    w_ea;
  logic [EXP_W-1:0]    w_eb;
  logic [EXP_W-1:0]    w_e;
  logic [EXP_W-1:0]    w_d;
  logic [EXP_W-1:0]    w_e_inc;
  logic [MANT_W-1:0]   w_ma;
  logic [MANT_W-1:0]   w_mb;
  logic [W-1:0]        w_result;
  logic                w_sat;

  assign w_xfer        = bus.in_valid && (r_state == IDLE);
  assign bus.in_ready  = (r_state == IDLE);
  assign bus.acc       = r_acc;
  assign bus.out_valid = r_out_valid;
  assign bus.ovf       = r_ovf;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (w_xfer) w_state_next = ALIGN;
      ALIGN:   w_state_next = ADD;
      ADD:     w_state_next = NORM;
      NORM:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Right shift by the exponent gap already yields zero once the gap reaches MANT_W.
  always_comb begin
    w_ea = r_opa[W-1:MANT_W];
    w_eb = r_opb[W-1:MANT_W];
    if (w_ea >= w_eb) begin
      w_e  = w_ea;
      w_d  = w_ea - w_eb;
      w_ma = r_opa[MANT_W-1:0];
      w_mb = r_opb[MANT_W-1:0] >> w_d;
    end else begin
      w_e  = w_eb;
      w_d  = w_eb - w_ea;
      w_ma = r_opa[MANT_W-1:0] >> w_d;
      w_mb = r_opb[MANT_W-1:0];
    end
  end

  always_comb begin
    w_e_inc  = r_exp + EXP_W'(1);
    w_sat    = 1'b0;
    w_result = {r_exp, r_sum[MANT_W-1:0]};
    if (r_sum[MANT_W]) begin
      if (r_exp != '1) begin
        w_result = {w_e_inc, r_sum[MANT_W:1]};
      end else begin
        w_result = '1;
        w_sat    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_opa       <= '0;
      r_opb       <= '0;
      r_acc       <= '0;
      r_exp       <= '0;
      r_ma        <= '0;
      r_mb        <= '0;
      r_sum       <= '0;
      r_out_valid <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_xfer) begin
            r_opa <= bus.in_clear ? '0 : r_acc;
            r_opb <= bus.in_data;
            if (bus.in_clear) r_ovf <= 1'b0;
          end
        end
        ALIGN: begin
          r_exp <= w_e;
          r_ma  <= w_ma;
          r_mb  <= w_mb;
        end
        ADD: begin
          r_sum <= {1'b0, r_ma} + {1'b0, r_mb};
        end
        NORM: begin
          r_acc       <= w_result;
          r_out_valid <= 1'b1;
          if (w_sat) r_ovf <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_float_acc.sv
// Directed bench for float_acc (EXP_W=3, MANT_W=5) with hand-computed sums.
module tb_float_acc;
  localparam int EW = 3;
  localparam int MW = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  float_acc_if #(.EXP_W(EW), .MANT_W(MW)) bus ();

  float_acc #(.EXP_W(EW), .MANT_W(MW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic       clr;
    logic [7:0] data;
    logic [7:0] exp_acc;
    logic       exp_ovf;
  } vec_t;

  vec_t tbl[17];

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08b expected %08b", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Called at a falling edge; returns just after the transfer edge.
  task automatic start_xfer(input logic clr, input logic [7:0] d, output bit ok);
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_clear = clr;
    for (int i = 0; i < 20; i++) begin
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL ready_timeout: in_ready never rose for data %08b", d);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_clear = 1'b0;
  endtask

  // Ends at the falling edge inside the out_valid cycle.
  task automatic finish_xfer(input string tag, input logic [7:0] ea, input logic eo);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check1({tag, "_busy_ready"}, bus.in_ready, 1'b0);
      check1({tag, "_busy_ovalid"}, bus.out_valid, 1'b0);
    end
    @(negedge clk);
    check1({tag, "_out_valid"}, bus.out_valid, 1'b1);
    check1({tag, "_ready"}, bus.in_ready, 1'b1);
    check8({tag, "_acc"}, bus.acc, ea);
    check1({tag, "_ovf"}, bus.ovf, eo);
  endtask

  task automatic send(input string tag, input logic clr, input logic [7:0] d,
                      input logic [7:0] ea, input logic eo);
    bit ok;
    start_xfer(clr, d, ok);
    if (ok) finish_xfer(tag, ea, eo);
  endtask

  initial begin
    bit ok;
    logic saw_ov;

    tbl[0]  = '{1'b1, 8'b00001000, 8'b00001000, 1'b0};
    tbl[1]  = '{1'b0, 8'b00000011, 8'b00001011, 1'b0};
    tbl[2]  = '{1'b0, 8'b00001100, 8'b00010111, 1'b0};
    tbl[3]  = '{1'b0, 8'b00110001, 8'b00111100, 1'b0};
    tbl[4]  = '{1'b1, 8'b00110001, 8'b00110001, 1'b0};
    tbl[5]  = '{1'b0, 8'b00001100, 8'b00110111, 1'b0};
    tbl[6]  = '{1'b1, 8'b10010010, 8'b10010010, 1'b0};
    tbl[7]  = '{1'b0, 8'b01011111, 8'b10011001, 1'b0};
    tbl[8]  = '{1'b1, 8'b11111110, 8'b11111110, 1'b0};
    tbl[9]  = '{1'b0, 8'b11111000, 8'b11111111, 1'b1};
    tbl[10] = '{1'b0, 8'b00000001, 8'b11111111, 1'b1};
    tbl[11] = '{1'b0, 8'b11100001, 8'b11111111, 1'b1};
    tbl[12] = '{1'b1, 8'b00000101, 8'b00000101, 1'b0};
    tbl[13] = '{1'b1, 8'b00011111, 8'b00011111, 1'b0};
    tbl[14] = '{1'b0, 8'b00000001, 8'b00110000, 1'b0};
    tbl[15] = '{1'b1, 8'b10100001, 8'b10100001, 1'b0};
    tbl[16] = '{1'b0, 8'b00011111, 8'b10100001, 1'b0};

    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_clear = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check8("rst_acc", bus.acc, 8'h00);
    check1("rst_out_valid", bus.out_valid, 1'b0);
    check1("rst_ovf", bus.ovf, 1'b0);
    check1("rst_ready", bus.in_ready, 1'b1);
    reset = 1'b0;
    @(negedge clk);

    foreach (tbl[i]) begin
      send($sformatf("vec%0d", i), tbl[i].clr, tbl[i].data, tbl[i].exp_acc, tbl[i].exp_ovf);
    end
    @(negedge clk);
    check1("pulse_one_cycle", bus.out_valid, 1'b0);

    // Saturate, then reset during ALIGN: operand dropped, ovf cleared.
    send("sat_a", 1'b1, 8'b11111110, 8'b11111110, 1'b0);
    send("sat_b", 1'b0, 8'b11111000, 8'b11111111, 1'b1);
    start_xfer(1'b0, 8'b00000001, ok);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check8("midrst_acc", bus.acc, 8'h00);
    check1("midrst_ready", bus.in_ready, 1'b1);
    check1("midrst_ovf", bus.ovf, 1'b0);
    saw_ov = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (bus.out_valid) saw_ov = 1'b1;
    end
    check1("midrst_no_out_valid", saw_ov, 1'b0);

    // Reset during ADD.
    send("pre_add", 1'b1, 8'b00000111, 8'b00000111, 1'b0);
    start_xfer(1'b0, 8'b00000001, ok);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check8("addrst_acc", bus.acc, 8'h00);
    check1("addrst_ready", bus.in_ready, 1'b1);
    check1("addrst_out_valid", bus.out_valid, 1'b0);
    send("post_rst", 1'b1, 8'b00000110, 8'b00000110, 1'b0);

    // Continuous in_valid: only data present in in_ready cycles is summed (1+5+9).
    send("stream_zero", 1'b1, 8'b00000000, 8'b00000000, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_clear = 1'b0;
    for (int i = 0; i < 12; i++) begin
      bus.in_data = 8'(i + 1);
      if (i == 4) begin
        check1("stream_ready4", bus.in_ready, 1'b1);
        check1("stream_ov4", bus.out_valid, 1'b1);
        check8("stream_acc4", bus.acc, 8'd1);
      end
      if (i == 8) begin
        check1("stream_ready8", bus.in_ready, 1'b1);
        check1("stream_ov8", bus.out_valid, 1'b1);
        check8("stream_acc8", bus.acc, 8'd6);
      end
      if (i == 2) check1("stream_busy2", bus.in_ready, 1'b0);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    check1("stream_ov_final", bus.out_valid, 1'b1);
    check8("stream_acc_final", bus.acc, 8'd15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/float_acc.md
Name: float_acc

Overview:
- Parametrised, multi-cycle accumulator for the team's unsigned mini-float format: value = mantissa << exponent, no hidden bit, no sign.
- Accepts a stream of operands over a valid/ready handshake and adds each one into a registered running sum.
- Uses the same align / truncate / normalise / saturate rules as the 8-bit combinational float adder.
- Sits between sample sources and downstream logic that needs a running total.

Parameters:
- EXP_W, 3, exponent field width (bits [EXP_W+MANT_W-1:MANT_W]).
- MANT_W, 5, mantissa field width (bits [MANT_W-1:0]).

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high.
- in_valid  input  1  operand present.
- in_ready  output  1  block can accept an operand this cycle.
- in_data  input  EXP_W+MANT_W  operand float.
- in_clear  input  1  sampled with in_data; when 1, accumulate onto zero instead of the current sum.
- acc  output  EXP_W+MANT_W  registered running sum.
- out_valid  output  1  one-cycle pulse: acc has just been updated.
- ovf  output  1  sticky saturation flag.

Behaviour:
- Reset values: acc=0, out_valid=0, ovf=0, state=IDLE, in_ready=1. Reset applies mid-operation too: any in-flight operand is discarded with no out_valid.
- FSM states: IDLE -> ALIGN -> ADD -> NORM -> IDLE. Each transition is unconditional except IDLE.
- in_ready = (state==IDLE). A transfer occurs on a rising edge with in_valid && in_ready.
- On transfer: capture in_data as operand B. Operand A is 0 if in_clear=1, otherwise acc. Go to ALIGN.
- ALIGN:
  - E = max(eA,eB); d = |eA-eB|.
  - Shift the mantissa of the smaller-exponent operand right by d, truncating (no rounding).
  - If d >= MANT_W, the shifted mantissa is 0.
  - Ties (equal exponents): no shift.
- ADD: sum = mA' + mB', width MANT_W+1.
- NORM:
  - If sum[MANT_W]=0: result = {E, sum[MANT_W-1:0]}.
  - If sum[MANT_W]=1 and E < 2^EXP_W-1: result = {E+1, sum[MANT_W:1]} (LSB truncated).
  - If sum[MANT_W]=1 and E = 2^EXP_W-1: result = all ones, and ovf is set.
  - acc <= result at the NORM edge.
- out_valid is high exactly during the cycle after NORM. In that cycle state is IDLE and in_ready=1.
- Latency: transfer edge T -> acc updated at edge T+3 -> out_valid high in cycle T+3..T+4.
- Throughput: 1 operand per 4 cycles. A back-to-back transfer is allowed in the same cycle out_valid is high.
- ovf:
  - Sticky; cleared only by reset, or by an accepted operand with in_clear=1. That clear happens at the transfer edge, and the operation may set ovf again at NORM.
  - When acc is saturated, further additions keep it all ones (carry re-saturates; a small operand truncates to no change).
- No left normalisation: sums never shrink, so canonical inputs yield canonical results.
- in_data and in_clear are sampled only at the transfer edge. Changes while busy are ignored.
- in_valid while busy: no transfer, no side effects. The source must hold in_valid until in_ready.

Test Plan (EXP_W=3, MANT_W=5):
- Reset, then send 00001000 with in_clear=1, then 00000011 -> acc=00001000, then acc=00001011. Each out_valid comes 3 edges after its transfer; in_ready is low for 3 cycles after each transfer.
- Continue the stream: send 00001100 -> acc=00010111 (exp0, 23). Then send 00110001 -> acc=00111100 (align truncation 23>>1=11; 17+11=28).
- in_clear=1 with 00110001, then 00001100 -> acc=00110111. Next in_clear=1 with 10010010, then 01011111 -> acc=10011001 (124 truncates; 18+7=25).
- in_clear=1 with 11111110, then 11111000 -> acc=11111111, ovf=1. Then send 00000001 -> acc stays 11111111, ovf stays 1. Then in_clear=1 with 00000101 -> acc=00000101, ovf=0.
- Assert reset during ALIGN or ADD of an operand -> no out_valid, acc=0, in_ready=1 on the next cycle. A subsequent clear-accumulate works normally.
- Hold in_valid high continuously with changing in_data -> only values present on in_ready cycles are summed. Check that in_ready and out_valid coincide in the same cycle.
